scale_change_dispenser: RTL

- Payment-side counterpart of the scale/cash-register accumulator.
- Accepts the finished sale total over a valid/ready handshake, collects inserted coins until the total is covered, then returns change one coin at a time over a valid/ready output.
- Supports customer cancel, which refunds everything inserted.

---
 rtl/scale_change_dispenser_pkg.sv | 21 ++
 rtl/scale_change_dispenser_if.sv | 29 ++
 rtl/scale_change_dispenser_change_sel.sv | 26 ++
 rtl/scale_change_dispenser.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/scale_change_dispenser_pkg.sv
// Shared types and constants for the change dispenser: FSM/mode enums, money widths,
// change denominations (largest first) and a saturating coin adder.
package scale_pkg;

  localparam int TOTAL_W = 21;
  localparam int COIN_W  = 11;

  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, DONE} state_t;
  typedef enum logic {SALE, REFUND} mode_t;

  // The smallest denomination must stay 1 so any change amount is payable exactly.
  localparam logic [TOTAL_W-1:0] DEN [0:3] = '{21'd1000, 21'd500, 21'd100, 21'd1};

  function automatic logic [TOTAL_W-1:0] sat_add(input logic [TOTAL_W-1:0] a,
                                                 input logic [COIN_W-1:0]  b);
    logic [TOTAL_W:0] s;
    s = {1'b0, a} + {{(TOTAL_W + 1 - COIN_W){1'b0}}, b};
    return s[TOTAL_W] ? {TOTAL_W{1'b1}} : s[TOTAL_W-1:0];
  endfunction

endpackage

// File: rtl/scale_change_dispenser_if.sv
// Handshake bundle between the payment environment (master) and the dispenser (slave).
interface scale_change_dispenser_if;
  import scale_pkg::*;

  logic               total_valid;
  logic [TOTAL_W-1:0] total;
  logic               total_ready;
  logic               coin_valid;
  logic [COIN_W-1:0]  coin_value;
  logic               cancel;
  logic               coin_out_valid;
  logic [1:0]         coin_out_denom;
  logic               coin_out_ready;
  logic [TOTAL_W-1:0] balance;
  logic               paid;
  logic               refunded;
  logic               busy;

  modport master (
    output total_valid, total, coin_valid, coin_value, cancel, coin_out_ready,
    input  total_ready, coin_out_valid, coin_out_denom, balance, paid, refunded, busy
  );

  modport slave (
    input  total_valid, total, coin_valid, coin_value, cancel, coin_out_ready,
    output total_ready, coin_out_valid, coin_out_denom, balance, paid, refunded, busy
  );

endinterface

// File: rtl/scale_change_dispenser_change_sel.sv
// Greedy change selector: largest denomination not exceeding the amount still owed.
// Purely combinational, zero latency; no handshake of its own.
module change_sel
  import scale_pkg::*;
(
  input  logic [TOTAL_W-1:0] change,
  output logic [1:0]         denom_idx,
  output logic [TOTAL_W-1:0] denom_val
);

  always_comb begin
    denom_idx = 2'd3;
    denom_val = DEN[3];
    if (change >= DEN[0]) begin
      denom_idx = 2'd0;
      denom_val = DEN[0];
    end else if (change >= DEN[1]) begin
      denom_idx = 2'd1;
      denom_val = DEN[1];
    end else if (change >= DEN[2]) begin
      denom_idx = 2'd2;
      denom_val = DEN[2];
    end
  end

endmodule

// File: rtl/scale_change_dispenser.sv
// Takes a sale total, collects coins until covered (or cancel/timeout), then pays change one coin per
// cycle. Latency: total->busy 1, covering coin->coin_out_valid 2; coin_out_denom held while stalled. Option: SCALE_CHANGE_TIMEOUT_EN.
module scale_change_dispenser
  import scale_pkg::*;
`ifdef SCALE_CHANGE_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYC = 1000
)
`endif
(
  input logic                     CLK,
  input logic                     reset,
  scale_change_dispenser_if.slave bus
);

  state_t             state, state_nxt;
  mode_t              mode, mode_nxt;
  logic [TOTAL_W-1:0] due, due_nxt;
  logic [TOTAL_W-1:0] inserted, inserted_nxt;
  logic [TOTAL_W-1:0] change, change_nxt;
  logic               paid_q, paid_nxt;
  logic               refunded_q, refunded_nxt;
  logic [TOTAL_W-1:0] ins_upd;
  logic [1:0]         den_idx;
  logic [TOTAL_W-1:0] den_val;
  logic               timeout;

  change_sel u_change_sel (
    .change    (change),
    .denom_idx (den_idx),
    .denom_val (den_val)
  );

`ifdef SCALE_CHANGE_TIMEOUT_EN
  logic [31:0] idle_cnt;

  // A coin arriving in the expiry cycle keeps the sale alive.
  assign timeout = (state == COLLECT) && !bus.coin_valid && (idle_cnt == 32'(TIMEOUT_CYC));

  always_ff @(posedge CLK) begin
    if (!reset || state != COLLECT || bus.coin_valid) begin
      idle_cnt <= '0;
    end else if (!timeout) begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state      <= IDLE;
      mode       <= SALE;
      due        <= '0;
      inserted   <= '0;
      change     <= '0;
      paid_q     <= 1'b0;
      refunded_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      mode       <= mode_nxt;
      due        <= due_nxt;
      inserted   <= inserted_nxt;
      change     <= change_nxt;
      paid_q     <= paid_nxt;
      refunded_q <= refunded_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    mode_nxt     = mode;
    due_nxt      = due;
    inserted_nxt = inserted;
    change_nxt   = change;
    paid_nxt     = 1'b0;
    refunded_nxt = 1'b0;
    ins_upd      = bus.coin_valid ? sat_add(inserted, bus.coin_value) : inserted;

    unique case (state)
      IDLE: begin
        if (bus.total_valid) begin
          due_nxt      = bus.total;
          inserted_nxt = '0;
          mode_nxt     = SALE;
          change_nxt   = '0;
          if (bus.total == '0) begin
            state_nxt = DONE;
            paid_nxt  = 1'b1;
          end else begin
            state_nxt = COLLECT;
          end
        end
      end
      COLLECT: begin
        inserted_nxt = ins_upd;
        // Cancel beats a covered total; a coin in the same cycle is still refunded.
        if (bus.cancel || timeout) begin
          change_nxt = ins_upd;
          mode_nxt   = REFUND;
          state_nxt  = DISPENSE;
        end else if (inserted >= due) begin
          change_nxt = ins_upd - due;
          mode_nxt   = SALE;
          state_nxt  = DISPENSE;
        end
      end
      DISPENSE: begin
        if (change == '0 || (bus.coin_out_ready && change == den_val)) begin
          change_nxt   = '0;
          state_nxt    = DONE;
          paid_nxt     = (mode == SALE);
          refunded_nxt = (mode == REFUND);
        end else if (bus.coin_out_ready) begin
          change_nxt = change - den_val;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.balance = '0;
    if (state == COLLECT) begin
      bus.balance = (inserted >= due) ? '0 : due - inserted;
    end else if (state == DISPENSE) begin
      bus.balance = change;
    end
  end

  assign bus.total_ready    = (state == IDLE);
  assign bus.busy           = (state != IDLE);
  assign bus.coin_out_valid = (state == DISPENSE) && (change != '0);
  assign bus.coin_out_denom = bus.coin_out_valid ? den_idx : 2'd0;
  assign bus.paid           = paid_q;
  assign bus.refunded       = refunded_q;

endmodule
